sample_stream_buffer: RTL

SAMPLE_STREAM_BUFFER -- requirements
Module: sample_stream_buffer

---
 rtl/audio_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/sample_stream_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions for the sample stream buffer.
// Holds the sample geometry (24-bit samples carried as three bytes),
// the FILL/PLAY playback state encoding and the byte-index wrap helper.
package audio_pkg;

   localparam int SAMPLE_W         = 24;
   localparam int BYTES_PER_SAMPLE = 3;
   localparam int BYTE_IDX_W       = 2;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_PLAY = 1'b1
   } play_state_t;

   // Byte position within a sample, wrapping after the last byte.
   function automatic logic [BYTE_IDX_W-1:0] next_byte_idx(input logic [BYTE_IDX_W-1:0] idx);
      if (idx == BYTE_IDX_W'(BYTES_PER_SAMPLE - 1)) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers/count only)
//   wr_en, wr_data  write request; accepted when not full or when a pop
//                   happens in the same cycle
//   rd_en           pop request; ignored while empty
//   rd_data         current head entry
//   full, empty     occupancy flags
//   level           number of stored entries (0..DEPTH)
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_rd;
   logic             do_wr;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign level   = count;
   assign rd_data = mem[rd_ptr];

   // A pop frees the head slot this cycle, so a full FIFO can still take
   // the write; when full, wr_ptr equals rd_ptr and the head is read out
   // before being overwritten.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/sample_stream_buffer.sv
// Byte-to-sample assembler and paced playback buffer.
// UART bytes are assembled little-endian into 24-bit samples, queued in a
// FIFO and released one per sample tick once PREFILL samples are buffered.
// Ports:
//   clk, rst_n     27 MHz clock, asynchronous active-low reset
//   data_in        received byte
//   byte_ready     data_in valid; only its rising edge accepts a byte
//   sample_out     current playback sample
//   sample_strobe  one-cycle pulse per sample tick
//   fifo_level     FIFO occupancy
//   playing        high in the PLAY state
//   underrun       pulse when a PLAY tick finds the FIFO empty
//   overflow       sticky, set when a sample is dropped
//   resync         pulse when a partial sample is dropped on gap timeout
module sample_stream_buffer
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV  = 612,
   parameter int FIFO_DEPTH  = 16,
   parameter int PREFILL     = 8,
   parameter int GAP_TIMEOUT = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    data_in,
   input  logic                          byte_ready,
   output logic [SAMPLE_W-1:0]           sample_out,
   output logic                          sample_strobe,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          playing,
   output logic                          underrun,
   output logic                          overflow,
   output logic                          resync
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int GW = $clog2(GAP_TIMEOUT);
   localparam logic [TW-1:0] TICK_LAST   = TW'(SAMPLE_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_TIMEOUT - 1);
   localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

   logic                  byte_ready_q;
   logic                  accept;
   logic [BYTE_IDX_W-1:0] byte_idx;
   logic [7:0]            byte0;
   logic [7:0]            byte1;
   logic [GW-1:0]         gap_cnt;
   logic                  wr_vld_p1;
   logic [SAMPLE_W-1:0]   wr_data_p1;
   logic [TW-1:0]         tick_cnt;
   logic                  tick;
   play_state_t           state;
   logic                  pop;
   logic [SAMPLE_W-1:0]   fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;

   assign accept = byte_ready & ~byte_ready_q;
   assign tick   = (tick_cnt == TICK_LAST);
   assign pop    = tick & (state == ST_PLAY) & ~fifo_empty;

   // Stage p0 -> p1: byte capture, assembly and gap supervision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_ready_q <= 1'b0;
         byte_idx     <= '0;
         gap_cnt      <= '0;
         resync       <= 1'b0;
         wr_vld_p1    <= 1'b0;
      end else begin
         byte_ready_q <= byte_ready;
         resync       <= 1'b0;
         wr_vld_p1    <= 1'b0;
         if (accept) begin
            gap_cnt  <= '0;
            byte_idx <= next_byte_idx(byte_idx);
            if (byte_idx == BYTE_IDX_W'(BYTES_PER_SAMPLE - 1)) begin
               wr_vld_p1 <= 1'b1;
            end
         end else if (byte_idx != '0) begin
            if (gap_cnt == GAP_LAST) begin
               gap_cnt  <= '0;
               byte_idx <= '0;
               resync   <= 1'b1;
            end else begin
               gap_cnt <= gap_cnt + 1'b1;
            end
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   // Byte holding registers carry data only; byte_idx decides their use.
   always_ff @(posedge clk) begin
      if (accept) begin
         case (byte_idx)
            2'd0:    byte0 <= data_in;
            2'd1:    byte1 <= data_in;
            default: wr_data_p1 <= {data_in, byte1, byte0};
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_vld_p1),
      .wr_data (wr_data_p1),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Stage p1 -> out: tick pacing and FILL/PLAY control.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt      <= '0;
         sample_strobe <= 1'b0;
         state         <= ST_FILL;
         playing       <= 1'b0;
         underrun      <= 1'b0;
         overflow      <= 1'b0;
         sample_out    <= '0;
      end else begin
         tick_cnt      <= tick ? '0 : tick_cnt + 1'b1;
         sample_strobe <= tick;
         underrun      <= 1'b0;
         if (wr_vld_p1 & fifo_full & ~pop) begin
            overflow <= 1'b1;
         end
         case (state)
            ST_FILL: begin
               if (fifo_level >= PREFILL_LVL) begin
                  state   <= ST_PLAY;
                  playing <= 1'b1;
               end
            end
            ST_PLAY: begin
               if (tick) begin
                  if (fifo_empty) begin
                     underrun <= 1'b1;
                     state    <= ST_FILL;
                     playing  <= 1'b0;
                  end else begin
                     sample_out <= fifo_head;
                  end
               end
            end
            default: begin
               state   <= ST_FILL;
               playing <= 1'b0;
            end
         endcase
      end
   end

endmodule
